// File: rtl/sram1024x18_arb.sv
// Two-requester round-robin arbiter in front of a 1024x18 single-port SRAM.
// After reset an optional sweep writes CLEAR_VAL to every word, then accesses
// are accepted one per cycle. Reads return two edges after acceptance.
module sram1024x18_arb #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [17:0] CLEAR_VAL      = 18'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [9:0]  req0_addr,
    input  logic [17:0] req0_wdata,
    input  logic [17:0] req0_wmask,
    output logic        resp0_valid,
    output logic [17:0] resp0_rdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [9:0]  req1_addr,
    input  logic [17:0] req1_wdata,
    input  logic [17:0] req1_wmask,
    output logic        resp1_valid,
    output logic [17:0] resp1_rdata,
    output logic        init_done,
    output logic        mem_cen,
    output logic        mem_wen,
    output logic [9:0]  mem_addr,
    output logic [17:0] mem_wmsk,
    output logic [17:0] mem_wdata,
    input  logic [17:0] mem_rdata
);
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  clr_cnt_q, clr_cnt_d;
    logic        clr_last_q, clr_last_d;   // last sweep write issued, one idle cycle before RUN
    logic        init_done_q, init_done_d;
    logic        last_q, last_d;           // 1 = req1 was granted last
    logic        mem_cen_q, mem_cen_d;
    logic        mem_wen_q, mem_wen_d;
    logic [9:0]  mem_addr_q, mem_addr_d;
    logic [17:0] mem_wmsk_q, mem_wmsk_d;
    logic [17:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  vld_q, vld_d;             // read-in-flight shift register
    logic [1:0]  id_q, id_d;               // requester id riding alongside vld
    logic        resp0_valid_q, resp0_valid_d;
    logic        resp1_valid_q, resp1_valid_d;
    logic [17:0] resp0_rdata_q, resp0_rdata_d;
    logic [17:0] resp1_rdata_q, resp1_rdata_d;

    logic        gnt0, gnt1, acc, sel_we;
    logic [9:0]  sel_addr;
    logic [17:0] sel_wdata, sel_wmask;

    // Round-robin grant; a tie goes to whoever was not granted last
    always_comb begin
        gnt0      = (state_q == ST_RUN) && req0_valid && (!req1_valid || last_q);
        gnt1      = (state_q == ST_RUN) && req1_valid && !gnt0;
        acc       = gnt0 || gnt1;
        sel_we    = gnt1 ? req1_we    : req0_we;
        sel_addr  = gnt1 ? req1_addr  : req0_addr;
        sel_wdata = gnt1 ? req1_wdata : req0_wdata;
        sel_wmask = gnt1 ? req1_wmask : req0_wmask;
    end

    // Next-state: clear sweep, accepted access, read response pipeline
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        clr_last_d    = clr_last_q;
        init_done_d   = init_done_q;
        last_d        = last_q;
        mem_cen_d     = 1'b1;
        mem_wen_d     = 1'b1;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wmsk_d    = '1;
        vld_d         = {vld_q[0], 1'b0};
        id_d          = {id_q[0], 1'b0};
        resp0_valid_d = vld_q[1] && !id_q[1];
        resp1_valid_d = vld_q[1] && id_q[1];
        resp0_rdata_d = resp0_valid_d ? mem_rdata : resp0_rdata_q;
        resp1_rdata_d = resp1_valid_d ? mem_rdata : resp1_rdata_q;
        case (state_q)
            ST_CLEAR: begin
                if (!clr_last_q) begin
                    mem_cen_d   = 1'b0;
                    mem_wen_d   = 1'b0;
                    mem_addr_d  = clr_cnt_q;
                    mem_wdata_d = CLEAR_VAL;
                    mem_wmsk_d  = '0;
                    clr_cnt_d   = clr_cnt_q + 10'd1;
                    if (clr_cnt_q == 10'd1023) clr_last_d = 1'b1;
                end else begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    clr_last_d  = 1'b0;
                end
            end
            default: begin
                if (acc) begin
                    mem_cen_d  = 1'b0;
                    mem_wen_d  = !sel_we;
                    mem_addr_d = sel_addr;
                    last_d     = gnt1;
                    vld_d[0]   = !sel_we;
                    id_d[0]    = gnt1;
                    if (sel_we) begin
                        mem_wdata_d = sel_wdata;
                        mem_wmsk_d  = ~sel_wmask;
                    end
                end
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q     <= '0;
            clr_last_q    <= 1'b0;
            init_done_q   <= !CLEAR_ON_RESET;
            last_q        <= 1'b1;
            mem_cen_q     <= 1'b1;
            mem_wen_q     <= 1'b1;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wmsk_q    <= '1;
            vld_q         <= '0;
            id_q          <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_rdata_q <= '0;
            resp1_rdata_q <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            clr_last_q    <= clr_last_d;
            init_done_q   <= init_done_d;
            last_q        <= last_d;
            mem_cen_q     <= mem_cen_d;
            mem_wen_q     <= mem_wen_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wmsk_q    <= mem_wmsk_d;
            vld_q         <= vld_d;
            id_q          <= id_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_rdata_q <= resp0_rdata_d;
            resp1_rdata_q <= resp1_rdata_d;
        end
    end

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;
    assign init_done   = init_done_q;
    assign mem_cen     = mem_cen_q;
    assign mem_wen     = mem_wen_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wmsk    = mem_wmsk_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_rdata = resp0_rdata_q;
    assign resp1_rdata = resp1_rdata_q;
endmodule

// File: doc/sram1024x18_arb.md
SRAM1024X18_ARB -- requirements
Module: sram1024x18_arb

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1: when 1, all 1024 words are written with CLEAR_VAL after reset before requests are served.
REQ-002 Parameter CLEAR_VAL [17:0], default 18'h0: data written during the clear sweep.
REQ-003 Port clk, input, 1: single clock; all state is on its rising edge; drives the SRAM port clock.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Ports req0_valid/req1_valid, input, 1 each: requester has an access pending.
REQ-006 Ports req0_ready/req1_ready, output, 1 each: access accepted this cycle.
REQ-007 Ports reqN_we, input, 1: 1 = write, 0 = read.
REQ-008 Ports reqN_addr, input, 10: word address.
REQ-009 Ports reqN_wdata, input, 18: write data.
REQ-010 Ports reqN_wmask, input, 18: per-bit write enable, 1 = write that bit.
REQ-011 Ports respN_valid, output, 1: one-cycle pulse, respN_rdata valid.
REQ-012 Ports respN_rdata, output, 18: read data.
REQ-013 Port init_done, output, 1: clear sweep complete; requests can be served.
REQ-014 Ports mem_cen/mem_wen, output, 1 each: active-low SRAM chip and write enables.
REQ-015 Port mem_addr, output, 10: SRAM address.
REQ-016 Ports mem_wmsk/mem_wdata, output, 18 each: mem_wmsk is active-low, 1 = keep bit.
REQ-017 Port mem_rdata, input, 18: SRAM read data, valid the cycle after the SRAM samples a read.

Function
REQ-018 FSM states are CLEAR and RUN; CLEAR_ON_RESET=1 enters CLEAR from reset, CLEAR_ON_RESET=0 enters RUN.
REQ-019 CLEAR: issue one write per cycle to addresses 0..1023 in order with data CLEAR_VAL and mem_wmsk all 0; after 1023, go to RUN and set init_done to 1.
REQ-020 In CLEAR, both reqN_ready are 0 and reqN_valid is ignored.
REQ-021 In RUN, reqN_ready is combinational and equals the grant: at most one requester is granted per cycle.
REQ-022 Arbitration is round-robin with a 1-bit last-grant pointer: one valid requester is granted; when both are valid, the requester not granted last wins.
REQ-023 The last-grant pointer updates only on an accepted access; reset value selects req1 as last, so req0 wins the first tie.
REQ-024 Acceptance at edge E (valid&ready) registers mem_* at E: mem_cen=0, mem_wen=~we, mem_addr=addr.
REQ-025 On an accepted write, mem_wdata=wdata and mem_wmsk=~wmask.
REQ-026 On an accepted read, mem_wmsk is all 1 and mem_wdata is held.
REQ-027 With no access, mem_cen=1, mem_wen=1 and mem_wmsk all 1 are registered at E.
REQ-028 Reads: the SRAM samples at E+1, mem_rdata is captured into respN_rdata at E+2, and respN_valid is high for the single cycle following E+2, N being the granted requester.
REQ-029 Throughput is one access per cycle; reads are pipelined, and up to 2 responses are in flight, tracked by a 2-stage valid/requester-id shift register.
REQ-030 Writes produce no response.
REQ-031 A write followed by a read of the same address on the next accept returns the written data.
REQ-032 respN_rdata holds its value when respN_valid is 0.
REQ-033 Back-to-back reads from alternating requesters each return in order with the correct requester id.

Reset
REQ-034 On rst assertion, asynchronously clear: FSM to initial state, clear counter 0, init_done=CLEAR_ON_RESET?0:1, pointer=req1, mem_cen=1, mem_wen=1, mem_addr=0, mem_wdata=0, mem_wmsk all 1, respN_valid=0, respN_rdata=0, pipeline empty.
REQ-035 Reset mid-sweep or mid-read drops all in-flight operations with no response; the sweep restarts from address 0.

Verification
REQ-036 CLEAR_ON_RESET=1, CLEAR_VAL=18'h15A5A, release reset -> exactly 1024 writes on addresses 0..1023, init_done rises one cycle after address 1023 is issued, ready stays 0 throughout.
REQ-037 req0 writes 18'h3FFFF to addr 5 with wmask 18'h000FF, then reads addr 5 (cleared to 0) -> resp0_rdata=18'h000FF, resp0_valid pulses exactly once, 2 edges after acceptance.
REQ-038 Both requesters hold valid reads for 6 cycles -> grants alternate 0,1,0,1,0,1 and responses alternate with matching ids and data.
REQ-039 Continuous req1 reads, with req0 valid for 1 cycle -> req0 is granted in that cycle if req1 was granted last, and req1 is delayed one cycle.
REQ-040 Assert rst at clear address 300, release -> sweep restarts at address 0 and init_done stays 0 until address 1023 is issued.
REQ-041 Assert rst one cycle after a read is accepted -> no respN_valid pulse, and all mem_* outputs at their idle values.
